// File: rtl/pw_mac_accum.sv
// pw_mac_accum
//   Pointwise (1x1) convolution multiply-accumulate stage. Takes the
//   channel-innermost activation stream from the pointwise tile reader.
//   For each element it reads one packed word of LANES signed weights,
//   one per output channel, and accumulates (act - zero_point) * weight
//   per lane. On the last input channel of a pixel the LANES accumulators
//   are presented on a valid/ready output register.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle pulse: latch cfg_*, (re)start a tile
//   cfg_w_base_addr     weight word address of input channel 0
//   cfg_in_zp           signed activation zero point
//   cfg_num_pix         pixels in the tile (>= 1)
//   in_valid/in_ready   activation handshake
//   in_data             signed activation
//   in_first_ch         first input channel of the pixel (restarts the sums)
//   in_last_ch          last input channel of the pixel (emits a result)
//   in_ch_idx           input channel index (addressing only)
//   w_rd_en/w_rd_addr   weight read request, issued in the accept cycle
//   w_rd_data           packed weights, lane 0 in LSBs, one cycle after w_rd_en
//   out_valid/out_ready result handshake
//   out_acc             packed accumulators, lane 0 in LSBs
//   out_pix_idx         pixel index of the presented result
//   busy                tile active
//   done                one-cycle pulse after the final result handshake
module pw_mac_accum #(
  parameter int DATA_W = 8,
  parameter int W_W    = 8,
  parameter int ACC_W  = 32,
  parameter int LANES  = 4,
  parameter int ADDR_W = 32,
  parameter int DIM_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      cfg_w_base_addr,
  input  logic [DATA_W-1:0]      cfg_in_zp,
  input  logic [DIM_W-1:0]       cfg_num_pix,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_first_ch,
  input  logic                   in_last_ch,
  input  logic [DIM_W-1:0]       in_ch_idx,
  output logic                   w_rd_en,
  output logic [ADDR_W-1:0]      w_rd_addr,
  input  logic [LANES*W_W-1:0]   w_rd_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*ACC_W-1:0] out_acc,
  output logic [DIM_W-1:0]       out_pix_idx,
  output logic                   busy,
  output logic                   done
);

  // state    | meaning
  // ST_IDLE  | no tile active, nothing accepted
  // ST_RUN   | accepting activations
  // ST_FINAL | last element of the last pixel accepted, draining its result
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FINAL} state_e;

  // zero-point subtraction needs one extra bit: 127 - (-128) = 255
  localparam int ACT_W  = DATA_W + 1;
  localparam int PROD_W = ACT_W + W_W;
  localparam int EXT_W  = (ACC_W > PROD_W) ? ACC_W : PROD_W;

  state_e                   state_q, state_d;
  logic [ADDR_W-1:0]        w_base_q, w_base_d;
  logic [DATA_W-1:0]        zp_q, zp_d;
  logic [DIM_W-1:0]         num_pix_q, num_pix_d;
  logic                     s1_valid_q, s1_valid_d;
  logic                     s1_first_q, s1_first_d;
  logic                     s1_last_q, s1_last_d;
  logic signed [ACT_W-1:0]  s1_act_q, s1_act_d;
  logic [LANES*ACC_W-1:0]   acc_q, acc_d;
  logic [LANES*ACC_W-1:0]   acc_upd;
  logic [LANES*ACC_W-1:0]   out_acc_q, out_acc_d;
  logic                     out_valid_q, out_valid_d;
  logic [DIM_W-1:0]         out_pix_q, out_pix_d;
  logic [DIM_W-1:0]         pix_cnt_q, pix_cnt_d;
  logic                     done_q, done_d;

  logic accept;
  logic out_hs;
  logic final_hs;
  logic final_accept;

  // An element following a last_ch element is held off for one cycle, so
  // pix_cnt_q always counts every earlier pixel when a last_ch element is
  // accepted; that makes the final-pixel test below exact.
  assign busy     = (state_q != ST_IDLE);
  assign in_ready = (state_q == ST_RUN) && (!out_valid_q || out_ready)
                    && !(s1_valid_q && s1_last_q);
  assign accept   = in_valid && in_ready;

  assign w_rd_en   = accept;
  assign w_rd_addr = accept ? (w_base_q + ADDR_W'(in_ch_idx)) : '0;

  assign out_hs       = out_valid_q && out_ready;
  assign final_hs     = out_hs && (out_pix_q == (num_pix_q - DIM_W'(1)));
  assign final_accept = accept && in_last_ch
                        && (pix_cnt_q == (num_pix_q - DIM_W'(1)));

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [W_W-1:0] w_lane;
    logic [ACC_W-1:0]      prod_acc;

    assign w_lane   = w_rd_data[g*W_W +: W_W];
    // product formed at full precision, then sign-extended or wrapped to ACC_W
    assign prod_acc = ACC_W'(EXT_W'(s1_act_q) * EXT_W'(w_lane));
    assign acc_upd[g*ACC_W +: ACC_W] = s1_first_q ? prod_acc
                                     : (acc_q[g*ACC_W +: ACC_W] + prod_acc);
  end

  always_comb begin
    state_d     = state_q;
    w_base_d    = w_base_q;
    zp_d        = zp_q;
    num_pix_d   = num_pix_q;
    s1_valid_d  = accept;
    s1_first_d  = accept ? in_first_ch : s1_first_q;
    s1_last_d   = accept ? in_last_ch : s1_last_q;
    s1_act_d    = accept ? (ACT_W'(signed'(in_data)) - ACT_W'(signed'(zp_q)))
                         : s1_act_q;
    acc_d       = acc_q;
    out_acc_d   = out_acc_q;
    out_valid_d = out_valid_q;
    out_pix_d   = out_pix_q;
    pix_cnt_d   = pix_cnt_q;
    done_d      = 1'b0;

    if (s1_valid_q) begin
      acc_d = acc_upd;
    end

    // the output register is always free when a last element reaches stage 1
    if (s1_valid_q && s1_last_q) begin
      out_acc_d   = acc_upd;
      out_valid_d = 1'b1;
      out_pix_d   = pix_cnt_q;
      pix_cnt_d   = pix_cnt_q + DIM_W'(1);
    end else if (out_hs) begin
      out_valid_d = 1'b0;
    end

    if (final_accept) begin
      state_d = ST_FINAL;
    end

    if (busy && final_hs) begin
      state_d = ST_IDLE;
      done_d  = 1'b1;
    end

    // restart discards everything in flight
    if (start) begin
      state_d     = ST_RUN;
      w_base_d    = cfg_w_base_addr;
      zp_d        = cfg_in_zp;
      num_pix_d   = cfg_num_pix;
      s1_valid_d  = 1'b0;
      acc_d       = acc_q;
      out_acc_d   = out_acc_q;
      out_valid_d = 1'b0;
      out_pix_d   = out_pix_q;
      pix_cnt_d   = '0;
      done_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      w_base_q    <= '0;
      zp_q        <= '0;
      num_pix_q   <= '0;
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_act_q    <= '0;
      acc_q       <= '0;
      out_acc_q   <= '0;
      out_valid_q <= 1'b0;
      out_pix_q   <= '0;
      pix_cnt_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_base_q    <= w_base_d;
      zp_q        <= zp_d;
      num_pix_q   <= num_pix_d;
      s1_valid_q  <= s1_valid_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      s1_act_q    <= s1_act_d;
      acc_q       <= acc_d;
      out_acc_q   <= out_acc_d;
      out_valid_q <= out_valid_d;
      out_pix_q   <= out_pix_d;
      pix_cnt_q   <= pix_cnt_d;
      done_q      <= done_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_acc     = out_acc_q;
  assign out_pix_idx = out_pix_q;
  assign done        = done_q;

endmodule

// File: tb/tb_pw_mac_accum.sv
// Self-checking bench for pw_mac_accum (LANES=2, ACC_W=16 so wrap is visible).
module tb_pw_mac_accum;
  localparam int DATA_W = 8;
  localparam int W_W    = 8;
  localparam int ACC_W  = 16;
  localparam int LANES  = 2;
  localparam int ADDR_W = 32;
  localparam int DIM_W  = 16;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   start = 1'b0;
  logic [ADDR_W-1:0]      cfg_w_base_addr = '0;
  logic [DATA_W-1:0]      cfg_in_zp = '0;
  logic [DIM_W-1:0]       cfg_num_pix = '0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [DATA_W-1:0]      in_data = '0;
  logic                   in_first_ch = 1'b0;
  logic                   in_last_ch = 1'b0;
  logic [DIM_W-1:0]       in_ch_idx = '0;
  logic                   w_rd_en;
  logic [ADDR_W-1:0]      w_rd_addr;
  logic [LANES*W_W-1:0]   w_rd_data = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [LANES*ACC_W-1:0] out_acc;
  logic [DIM_W-1:0]       out_pix_idx;
  logic                   busy;
  logic                   done;

  pw_mac_accum #(
    .DATA_W(DATA_W), .W_W(W_W), .ACC_W(ACC_W),
    .LANES(LANES), .ADDR_W(ADDR_W), .DIM_W(DIM_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_w_base_addr(cfg_w_base_addr), .cfg_in_zp(cfg_in_zp),
    .cfg_num_pix(cfg_num_pix),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_first_ch(in_first_ch), .in_last_ch(in_last_ch), .in_ch_idx(in_ch_idx),
    .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .out_pix_idx(out_pix_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { int act; int first; int last; int ch; } elem_t;
  typedef elem_t elem_q_t[$];
  typedef struct { logic [LANES*ACC_W-1:0] acc; logic [DIM_W-1:0] idx; } res_t;
  typedef res_t res_q_t[$];
  typedef struct { int act; int exp0; int exp1; } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int wmem [256][LANES];
  res_q_t res_q;
  logic [ADDR_W-1:0] addr_q[$];
  int done_cnt = 0;
  int last_acc_cyc = 0, ov_rise_cyc = 0, hs_cyc = 0, done_cyc = 0;
  logic ov_prev = 1'b0;
  int rdy_mode = 0;

  // weight memory: registered read, data valid the cycle after w_rd_en
  always @(posedge clk) begin
    cyc++;
    if (w_rd_en)
      for (int l = 0; l < LANES; l++)
        w_rd_data[l*W_W +: W_W] <= W_W'(wmem[w_rd_addr[7:0]][l]);
  end

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      res_q.push_back('{out_acc, out_pix_idx});
      hs_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (w_rd_en) addr_q.push_back(w_rd_addr);
    if (in_valid && in_ready && in_last_ch) last_acc_cyc = cyc;
    if (out_valid && !ov_prev) ov_rise_cyc = cyc;
    ov_prev = out_valid;
  end

  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no end expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic res_t mk_res(input int l0, input int l1, input int idx);
    res_t r;
    r.acc = {ACC_W'(l1), ACC_W'(l0)};
    r.idx = DIM_W'(idx);
    return r;
  endfunction

  // reference: per-pixel dot products over the element list, wrapped to ACC_W
  function automatic res_q_t model(input elem_q_t q, input int zp, input int base);
    res_q_t r;
    int sum [LANES];
    int pix = 0;
    foreach (sum[l]) sum[l] = 0;
    foreach (q[i]) begin
      for (int l = 0; l < LANES; l++) begin
        if (q[i].first != 0) sum[l] = 0;
        sum[l] += (q[i].act - zp) * wmem[(base + q[i].ch) & 255][l];
      end
      if (q[i].last != 0) begin
        res_t x;
        for (int l = 0; l < LANES; l++) x.acc[l*ACC_W +: ACC_W] = ACC_W'(sum[l]);
        x.idx = DIM_W'(pix);
        pix++;
        r.push_back(x);
      end
    end
    return r;
  endfunction

  task automatic compare_results(input string name, input res_q_t exp);
    check({name, " count"}, res_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < res_q.size(); i++) begin
      for (int l = 0; l < LANES; l++)
        check($sformatf("%s pix%0d lane%0d", name, i, l),
              longint'($signed(res_q[i].acc[l*ACC_W +: ACC_W])),
              longint'($signed(exp[i].acc[l*ACC_W +: ACC_W])));
      check($sformatf("%s pix%0d idx", name, i), res_q[i].idx, exp[i].idx);
    end
  endtask

  task automatic start_tile(input int base, input int zp, input int npix);
    res_q.delete();
    addr_q.delete();
    done_cnt = 0;
    start = 1'b1;
    cfg_w_base_addr = ADDR_W'(base);
    cfg_in_zp = DATA_W'(zp);
    cfg_num_pix = DIM_W'(npix);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_elem(input elem_t e, input int gap);
    int n = 0;
    repeat (gap) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data = DATA_W'(e.act);
    in_first_ch = (e.first != 0);
    in_last_ch = (e.last != 0);
    in_ch_idx = DIM_W'(e.ch);
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      n++;
      if (n > 300) begin
        check("in_ready timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic drive_stream(input elem_q_t q, input int max_gap);
    foreach (q[i]) send_elem(q[i], int'($urandom_range(0, max_gap)));
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (done_cnt < 1 && k < 3000) begin
      @(posedge clk); #1;
      k++;
    end
    if (done_cnt < 1) check({name, " done timeout"}, 0, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  elem_q_t q;
  res_q_t exp;
  vec_t tv [4];
  logic [LANES*ACC_W-1:0] held;
  int changes, k;

  initial begin
    tv = '{'{5, 10, -10}, '{-3, -6, 6}, '{7, 14, -14}, '{0, 0, 0}};
    foreach (wmem[a, l]) wmem[a][l] = 0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst in_ready", in_ready, 0);
    check("rst w_rd_en", w_rd_en, 0);
    check("rst w_rd_addr", w_rd_addr, 0);
    check("rst out_valid", out_valid, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst out_acc", out_acc, 0);
    check("rst out_pix_idx", out_pix_idx, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    // 1: three channels, one pixel
    wmem[8'h40] = '{1, -1};
    wmem[8'h41] = '{2, 0};
    wmem[8'h42] = '{3, 4};
    q = '{'{1, 1, 0, 0}, '{2, 0, 0, 1}, '{3, 0, 1, 2}};
    start_tile(32'h40, 0, 1);
    check("t1 busy after start", busy, 1);
    drive_stream(q, 0);
    wait_done("t1");
    exp = '{mk_res(14, 11, 0)};
    compare_results("t1", exp);
    check("t1 addr count", addr_q.size(), 3);
    for (int i = 0; i < 3 && i < addr_q.size(); i++)
      check($sformatf("t1 addr%0d", i), addr_q[i], 32'h40 + i);
    check("t1 latency", ov_rise_cyc - last_acc_cyc, 2);
    check("t1 done delay", done_cyc - hs_cyc, 1);
    check("t1 done count", done_cnt, 1);
    check("t1 busy after done", busy, 0);

    // 2: single-channel pixels streamed back to back
    wmem[8'h80] = '{2, -2};
    start_tile(32'h80, 0, 4);
    for (int i = 0; i < 4; i++) send_elem('{tv[i].act, 1, 1, 0}, 0);
    in_valid = 1'b0;
    wait_done("t2");
    check("t2 count", res_q.size(), 4);
    for (int i = 0; i < 4 && i < res_q.size(); i++) begin
      exp = '{mk_res(tv[i].exp0, tv[i].exp1, i)};
      check($sformatf("t2 pix%0d lanes", i), res_q[i].acc, exp[0].acc);
      check($sformatf("t2 pix%0d idx", i), res_q[i].idx, i);
    end
    check("t2 done count", done_cnt, 1);

    // 3: result held under backpressure
    for (int c = 0; c < 2; c++)
      for (int l = 0; l < LANES; l++) wmem[8'h10 + c][l] = int'($urandom_range(0, 255)) - 128;
    q = {};
    for (int p = 0; p < 3; p++) begin
      q.push_back('{int'($urandom_range(0, 255)) - 128, 1, 0, 0});
      q.push_back('{int'($urandom_range(0, 255)) - 128, 0, 1, 1});
    end
    exp = model(q, 3, 32'h10);
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    start_tile(32'h10, 3, 3);
    fork
      drive_stream(q, 0);
      begin
        k = 0;
        while (!out_valid && k < 200) begin
          @(negedge clk);
          k++;
        end
        check("t3 out_valid seen", out_valid, 1);
        held = out_acc;
        changes = 0;
        repeat (10) begin
          @(negedge clk);
          if (out_acc !== held || !out_valid) changes++;
        end
        check("t3 stable", changes, 0);
        check("t3 in_ready held low", in_ready, 0);
        check("t3 held value", held, exp[0].acc);
        check("t3 no handshake", res_q.size(), 0);
        @(posedge clk); #1;
        rdy_mode = 0;
      end
    join
    wait_done("t3");
    compare_results("t3", exp);

    // 4: 2*255*127 = 64770 wraps in 16 bits to 64770-65536 = -766
    wmem[8'h20] = '{127, 127};
    wmem[8'h21] = '{127, 127};
    q = '{'{127, 1, 0, 0}, '{127, 0, 1, 1}};
    start_tile(32'h20, -128, 1);
    drive_stream(q, 0);
    wait_done("t4");
    exp = '{mk_res(-766, -766, 0)};
    compare_results("t4", exp);

    // 5: restart while a pixel's last element is in stage 1
    q = '{'{1, 1, 0, 0}, '{2, 0, 0, 1}, '{3, 0, 1, 2}};
    start_tile(32'h40, 0, 2);
    drive_stream(q, 0);
    start_tile(32'h80, 0, 1);
    send_elem('{5, 1, 1, 0}, 0);
    in_valid = 1'b0;
    wait_done("t5");
    exp = '{mk_res(10, -10, 0)};
    compare_results("t5", exp);
    check("t5 done count", done_cnt, 1);

    // 6: reset while a result is pending
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    start_tile(32'h80, 0, 2);
    send_elem('{5, 1, 1, 0}, 0);
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("t6 out_valid before reset", out_valid, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6 out_valid", out_valid, 0);
    check("t6 busy", busy, 0);
    check("t6 in_ready", in_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    check("t6 no done", done_cnt, 0);
    rst_n = 1'b1;
    rdy_mode = 1;
    @(posedge clk); #1;

    // random tiles against the reference model
    for (int t = 0; t < 6; t++) begin
      int base, zp, npix, nch;
      base = int'($urandom_range(0, 250));
      zp = int'($urandom_range(0, 255)) - 128;
      npix = int'($urandom_range(1, 5));
      for (int c = 0; c < 4; c++)
        for (int l = 0; l < LANES; l++)
          wmem[(base + c) & 255][l] = int'($urandom_range(0, 255)) - 128;
      q = {};
      for (int p = 0; p < npix; p++) begin
        nch = int'($urandom_range(1, 4));
        for (int c = 0; c < nch; c++)
          q.push_back('{int'($urandom_range(0, 255)) - 128, int'(c == 0),
                        int'(c == nch - 1), c});
      end
      exp = model(q, zp, base);
      start_tile(base, zp, npix);
      drive_stream(q, 2);
      wait_done($sformatf("rnd%0d", t));
      compare_results($sformatf("rnd%0d", t), exp);
      check($sformatf("rnd%0d done count", t), done_cnt, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
